// File: rtl/hba_arb_pkg.sv
// Shared constants and state encoding for the HBA bus arbiter.
package hba_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  localparam int unsigned MAX_MASTERS      = 8;
  localparam int unsigned DEFAULT_MAX_HOLD = 255;

endpackage

// File: rtl/hba_rr_pick.sv
// Combinational rotate-priority picker: first set request at or above the
// pointer, wrapping modulo N.
module hba_rr_pick #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_onehot,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  always_comb begin
    int unsigned j;
    j        = 0;
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (32'(i_ptr) + k) % N;
      if (!o_any && i_req[j]) begin
        o_any       = 1'b1;
        o_onehot[j] = 1'b1;
        o_idx       = IW'(j);
      end
    end
  end

endmodule

// File: rtl/hba_arbiter.sv
// Round-robin HBA bus arbiter with registered one-hot grant and a forced
// one-cycle gap between owners. Define HBA_ARB_TIMEOUT_EN to bound tenure.
module hba_arbiter
  import hba_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned ID_WIDTH    = 1,
  parameter int unsigned MAX_HOLD    = DEFAULT_MAX_HOLD
) (
  input  logic                   hba_clk,
  input  logic                   hba_reset,
  input  logic [NUM_MASTERS-1:0] hba_mreq,
  output logic [NUM_MASTERS-1:0] hba_mgrant,
  output logic                   hba_grant_valid,
  output logic [ID_WIDTH-1:0]    hba_grant_id,
  output logic                   hba_arb_timeout
);

  if (NUM_MASTERS < 2 || NUM_MASTERS > MAX_MASTERS || ID_WIDTH < $clog2(NUM_MASTERS) ||
      MAX_HOLD < 1) begin : g_bad_cfg
    $error("hba_arbiter: illegal parameter combination");
  end

  arb_state_e             r_state, w_state_d;
  logic [NUM_MASTERS-1:0] r_mgrant, w_mgrant_d;
  logic [ID_WIDTH-1:0]    r_grant_id, w_grant_id_d;
  logic                   r_valid, w_valid_d;
  logic [ID_WIDTH-1:0]    r_ptr, w_ptr_d;

  logic [NUM_MASTERS-1:0] w_elig;
  logic [NUM_MASTERS-1:0] w_win_onehot;
  logic [ID_WIDTH-1:0]    w_win_idx;
  logic                   w_win_any;
  logic [ID_WIDTH-1:0]    w_ptr_next;
  logic                   w_owner_req;

`ifdef HBA_ARB_TIMEOUT_EN
  localparam int unsigned HoldW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD);
  logic [HoldW-1:0]       r_hold, w_hold_d;
  logic [NUM_MASTERS-1:0] r_mask, w_mask_d;
  logic                   r_timeout, w_timeout_d;

  assign w_elig          = hba_mreq & ~r_mask;
  assign hba_arb_timeout = r_timeout;
`else
  assign w_elig          = hba_mreq;
  assign hba_arb_timeout = 1'b0;
`endif

  hba_rr_pick #(
    .N  (NUM_MASTERS),
    .IW (ID_WIDTH)
  ) u_pick (
    .i_req    (w_elig),
    .i_ptr    (r_ptr),
    .o_onehot (w_win_onehot),
    .o_idx    (w_win_idx),
    .o_any    (w_win_any)
  );

  assign w_ptr_next  = ID_WIDTH'((32'(w_win_idx) + 1) % NUM_MASTERS);
  assign w_owner_req = |(hba_mreq & r_mgrant);

  always_comb begin
    w_state_d    = r_state;
    w_mgrant_d   = r_mgrant;
    w_grant_id_d = r_grant_id;
    w_valid_d    = r_valid;
    w_ptr_d      = r_ptr;
`ifdef HBA_ARB_TIMEOUT_EN
    w_hold_d     = r_hold;
    w_timeout_d  = 1'b0;
    // A blocked master stays blocked until it is seen idle once.
    w_mask_d     = r_mask & hba_mreq;
`endif
    unique case (r_state)
      ARB_IDLE: begin
        if (w_win_any) begin
          w_state_d    = ARB_GRANT;
          w_mgrant_d   = w_win_onehot;
          w_grant_id_d = w_win_idx;
          w_valid_d    = 1'b1;
          w_ptr_d      = w_ptr_next;
`ifdef HBA_ARB_TIMEOUT_EN
          w_hold_d     = '0;
`endif
        end
      end
      ARB_GRANT: begin
        if (!w_owner_req) begin
          w_state_d    = ARB_IDLE;
          w_mgrant_d   = '0;
          w_grant_id_d = '0;
          w_valid_d    = 1'b0;
`ifdef HBA_ARB_TIMEOUT_EN
        end else if (32'(r_hold) == MAX_HOLD - 1) begin
          // r_hold counts completed grant cycles, so this revoke lands after MAX_HOLD.
          w_state_d    = ARB_IDLE;
          w_mgrant_d   = '0;
          w_grant_id_d = '0;
          w_valid_d    = 1'b0;
          w_timeout_d  = 1'b1;
          w_mask_d     = w_mask_d | r_mgrant;
        end else begin
          w_hold_d     = r_hold + 1'b1;
`endif
        end
      end
      default: w_state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge hba_clk) begin
    if (hba_reset) begin
      r_state    <= ARB_IDLE;
      r_mgrant   <= '0;
      r_grant_id <= '0;
      r_valid    <= 1'b0;
      r_ptr      <= '0;
`ifdef HBA_ARB_TIMEOUT_EN
      r_hold     <= '0;
      r_mask     <= '0;
      r_timeout  <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_d;
      r_mgrant   <= w_mgrant_d;
      r_grant_id <= w_grant_id_d;
      r_valid    <= w_valid_d;
      r_ptr      <= w_ptr_d;
`ifdef HBA_ARB_TIMEOUT_EN
      r_hold     <= w_hold_d;
      r_mask     <= w_mask_d;
      r_timeout  <= w_timeout_d;
`endif
    end
  end

  assign hba_mgrant      = r_mgrant;
  assign hba_grant_valid = r_valid;
  assign hba_grant_id    = r_grant_id;

endmodule

// File: doc/hba_arbiter.md
Name: hba_arbiter

Overview:
Round-robin arbiter that shares the single HBA bus between several bus masters, for example serial_fpga and a future autonomous poller. It sits between the masters' request/grant pins and the HBA address/data mux, and drives the one-hot grant that selects the mux input. Grants are registered. The block guarantees a one-cycle dead gap between owners so the bus mux and slave select lines settle.

Parameters:
NUM_MASTERS, 2, number of requesting masters (2..8)
ID_WIDTH, 1, width of hba_grant_id; must be >= clog2(NUM_MASTERS), minimum 1
MAX_HOLD, 255, maximum consecutive granted cycles before forced revoke (used only with HBA_ARB_TIMEOUT_EN)

Ports:
hba_clk  input  1  bus clock; all logic on rising edge
hba_reset  input  1  synchronous, active-high reset
hba_mreq  input  NUM_MASTERS  per-master bus request; level, held for the whole bus tenure
hba_mgrant  output  NUM_MASTERS  one-hot (or zero) registered grant
hba_grant_valid  output  1  OR of hba_mgrant
hba_grant_id  output  ID_WIDTH  index of granted master; 0 when no grant
hba_arb_timeout  output  1  one-cycle pulse on forced revoke; constant 0 without the macro

Behaviour:
- Clock and reset: one clock, hba_clk. Reset is synchronous and active-high on hba_reset.
- Reset values: hba_mgrant=0, hba_grant_valid=0, hba_grant_id=0, hba_arb_timeout=0, state=IDLE, priority pointer=0 (master 0 highest), hold counter=0, block mask=0.
- FSM states: IDLE, GRANT.
- IDLE:
  - If any eligible request (hba_mreq & ~block_mask) is high at edge t, register the winner and enter GRANT.
  - hba_mgrant is visible from t+1, a 1-cycle request-to-grant latency.
  - With no eligible request, stay in IDLE.
- Winner selection: first set bit scanning upward from the pointer, wrapping modulo NUM_MASTERS. On grant to master i, the pointer becomes (i+1) mod NUM_MASTERS.
- GRANT:
  - The grant holds while the owner's hba_mreq=1. Other requests are ignored; there is no preemption.
  - If the owner's hba_mreq=0 at edge t, then at t+1 grant=0 and state=IDLE.
  - The earliest next grant is at t+2, so at least one cycle always has grant=0 between owners.
- Same master re-requesting: if the owner drops its request for one cycle and raises it again, it competes normally. Round-robin lets other pending masters win first.
- Simultaneous requests in IDLE: the pointer order decides. Exactly one grant bit is ever set.
- Reset mid-tenure: the grant drops on the next edge, with no gap cycle owed. The pointer returns to 0.
- Out-of-range grant_id cannot occur. Request bits at or above NUM_MASTERS do not exist.
- hba_grant_id and hba_grant_valid are registered alongside hba_mgrant and are always consistent with it.

Optional Feature:
HBA_ARB_TIMEOUT_EN
- Defined:
  - The hold counter increments each GRANT cycle and clears on entry to GRANT.
  - When the counter reaches MAX_HOLD with the request still high, grant clears at the next edge, state goes to IDLE, and hba_arb_timeout pulses for 1 cycle.
  - The offending master's block_mask bit is set. That bit clears when its hba_mreq is sampled 0, and the master is ineligible while blocked.
  - The owner therefore holds the grant for exactly MAX_HOLD cycles.
- Undefined: no counter and no mask logic; hba_arb_timeout tied to 0; tenure is unbounded.

Decomposition:
- Package hba_arb_pkg holds:
  - state encodings ARB_IDLE=1'b0 and ARB_GRANT=1'b1;
  - the MAX_MASTERS=8 limit constant;
  - the default MAX_HOLD value.
- Sub-module hba_rr_pick: combinational rotate-priority picker. Inputs are the request vector and the pointer; outputs are a one-hot winner, the winner index and an any flag. The parent instantiates it once.

Test Plan:
1. Reset, then hba_mreq=2'b01 at cycle 5 -> hba_mgrant=2'b01 and grant_id=0 at cycle 6; the grant holds until req drops; grant=0 one cycle after the drop.
2. Both requests high from reset release -> master0 granted first. When master0 drops its request at t, grant=0 at t+1 and master1 is granted at t+2 with grant_id=1.
3. NUM_MASTERS=4 with all requests held and each owner releasing after 3 cycles -> grant order 0,1,2,3,0; each tenure is 3 cycles plus a 1-cycle gap.
4. hba_reset asserted while master1 is granted -> grant=0 on the next edge. After release with all requests high, master0 wins (pointer is back at 0).
5. With HBA_ARB_TIMEOUT_EN, MAX_HOLD=4, master0 holds its request -> grant lasts exactly 4 cycles, hba_arb_timeout pulses once, and master0 is not regranted until its req goes 0 and then 1. Master1, if requesting, is granted 1 cycle after the revoke.
6. Without the macro, master0 holds its request for 1000 cycles -> the grant never drops and hba_arb_timeout stays 0.
